// File: rtl/arb_mux_n_pkg.sv
// mux_pkg: shared width helpers and one-hot encoder for the arbitrating mux family
package mux_pkg;

    localparam int W_DEF = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int onehot_idx(input logic [63:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) if (oh[i]) r = r | i;
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// arb_mux_n_if: N producer valid/ready channels plus one registered consumer channel
interface arb_mux_n_if import mux_pkg::*; #(
    parameter int N = 4,
    parameter int W = W_DEF,
    localparam int SELW = clog2(N)
) ();
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_sel;
    logic            out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/arb_mux_n_rr_arbiter.sv
// rr_arbiter: round-robin grant over N requests; ARB_MUX_FIXED_PRIO_EN makes it a lowest-index priority encoder
module rr_arbiter import mux_pkg::*; #(
    parameter int N = 4,
    localparam int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx
);
    logic [N-1:0] pick;
`ifdef ARB_MUX_FIXED_PRIO_EN
    logic unused;
    assign unused = clk ^ rst_n;
    assign pick = req;
`else
    logic [SELW-1:0] rr_ptr;
    logic [N-1:0]    hi;
    // requests at or above rr_ptr win first; otherwise wrap to the lowest request
    assign hi   = req & ~((N'(1) << rr_ptr) - N'(1));
    assign pick = |hi ? hi : req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else if (|gnt) rr_ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
    end
`endif
    assign gnt     = en ? pick & (~pick + N'(1)) : '0;
    assign gnt_idx = SELW'(onehot_idx(64'(gnt)));
endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbitrating mux with a one-deep registered output stage
// ARB_MUX_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin
module arb_mux_n import mux_pkg::*; #(
    parameter int N = 4,
    parameter int W = W_DEF,
    localparam int SELW = clog2(N)
) (
    input logic        clk,
    input logic        rst_n,
    arb_mux_n_if.slave bus
);
    logic            ld;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] gnt_idx;
    logic [W-1:0]    sel_data;
    // gating with rst_n keeps in_ready low while reset is held
    assign ld = rst_n && (!bus.out_valid || bus.out_ready);
    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.in_valid),
        .en      (ld),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );
    assign bus.in_ready = gnt;
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) sel_data = sel_data | (bus.in_data[i*W +: W] & {W{gnt[i]}});
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (ld) begin
            bus.out_valid <= |gnt;
            if (|gnt) begin
                bus.out_data <= sel_data;
                bus.out_sel  <= gnt_idx;
            end
        end
    end
endmodule
